// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one add/sub FSM unit between two requesters.
// Optional abort-on-timeout path enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_addsub_arbiter #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_op,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        fpu_start,
  output logic [31:0] fpu_n1,
  output logic [31:0] fpu_n2,
  output logic        fpu_sel,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (TIMEOUT < 8 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fpu_addsub_arbiter: TIMEOUT must be within 8..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_id_q, grant_id_d;
  logic [31:0] n1_q, n1_d;
  logic [31:0] n2_q, n2_d;
  logic        sel_q, sel_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic        pulse_q, pulse_d;
  logic        timeout_hit;
  logic        any_valid;
  logic        winner;

`ifdef FPU_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Held at zero in IDLE so the count starts fresh on every ISSUE entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = 8'd0;
    end else if (state_q == S_ISSUE) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == S_ISSUE) && (cnt_q == 8'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Contention goes to whichever requester was not served last.
  assign any_valid = req0_valid | req1_valid;
  assign winner    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  assign req0_ready = rst_n && (state_q == S_IDLE) && any_valid && !winner;
  assign req1_ready = rst_n && (state_q == S_IDLE) && any_valid && winner;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    n1_d         = n1_q;
    n2_d         = n2_q;
    sel_d        = sel_q;
    result_d     = result_q;
    err_d        = err_q;
    pulse_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d      = S_ISSUE;
          grant_id_d   = winner;
          last_grant_d = winner;
          n1_d         = winner ? req1_a  : req0_a;
          n2_d         = winner ? req1_b  : req0_b;
          sel_d        = winner ? req1_op : req0_op;
        end
      end
      S_ISSUE: begin
        if (fpu_done) begin
          state_d  = S_DRAIN;
          result_d = fpu_result;
          err_d    = 1'b0;
          pulse_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d  = S_DRAIN;
          result_d = QNAN;
          err_d    = 1'b1;
          pulse_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        // The unit only returns to idle after start falls, so wait for done low.
        if (!fpu_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      n1_q         <= 32'd0;
      n2_q         <= 32'd0;
      sel_q        <= 1'b0;
      result_q     <= 32'd0;
      err_q        <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      n1_q         <= n1_d;
      n2_q         <= n2_d;
      sel_q        <= sel_d;
      result_q     <= result_d;
      err_q        <= err_d;
      pulse_q      <= pulse_d;
    end
  end

  assign fpu_start   = (state_q == S_ISSUE);
  assign fpu_n1      = n1_q;
  assign fpu_n2      = n2_q;
  assign fpu_sel     = sel_q;
  assign busy        = (state_q != S_IDLE);
  assign grant_id    = grant_id_q;
  assign resp0_valid = pulse_q && !grant_id_q;
  assign resp1_valid = pulse_q && grant_id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;

endmodule
